// File: rtl/pwm_capture_8bit.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture_8bit
// Purpose  : Measures PWM high time and period and publishes the duty cycle as
//            floor(high*256/period) through a valid/ack handshake.
//            Optional macro PWM_CAP_AVG_EN averages consecutive results.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_capture_8bit #(
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwmin,
    input  logic       cscap,
    input  logic       sample_ack,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic [7:0] status
);

    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MIN      = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] c_CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
`ifdef PWM_CAP_AVG_EN
    localparam logic [3:0]       c_PUB_ITER = 4'd9;
`else
    localparam logic [3:0]       c_PUB_ITER = 4'd8;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_sync1, r_sync2, r_hist;
    logic [CNT_W-1:0] r_per_cnt, r_high_cnt;
    logic             r_div_busy;
    logic [3:0]       r_div_iter;
    logic [CNT_W-1:0] r_rem, r_divisor;
    logic [7:0]       r_quot;
    logic [7:0]       r_sample;
    logic             r_valid, r_ovr, r_tmo, r_glitch;
`ifdef PWM_CAP_AVG_EN
    logic [7:0]       r_q_prev, r_avg;
    logic             r_have_prev;
    logic [8:0]       w_avg_sum;
`endif

    logic             w_rise, w_fall;
    logic             w_accept, w_reject, w_timeout;
    logic             w_div_pub, w_pub;
    logic [7:0]       w_div_val, w_pub_val;
    logic [CNT_W:0]   w_rem_sh;
    logic [CNT_W-1:0] w_rem_sub;
    logic             w_q_bit;

    assign w_rise = r_sync2 & ~r_hist;
    assign w_fall = ~r_sync2 & r_hist;

    assign w_accept  = cscap && (r_state == S_LOW) && w_rise && (r_per_cnt >= c_MIN);
    assign w_reject  = cscap && (r_state == S_LOW) && w_rise && (r_per_cnt < c_MIN);
    assign w_timeout = cscap && (r_per_cnt == c_CNT_LAST) &&
                       (((r_state == S_HIGH) && !w_fall) || ((r_state == S_LOW) && !w_rise));

    // Remainder stays below the divisor, so the shifted value fits CNT_W+1 bits
    // and the low CNT_W bits of the difference are exact whenever it is taken.
    assign w_rem_sh  = {r_rem, 1'b0};
    assign w_rem_sub = w_rem_sh[CNT_W-1:0] - r_divisor;
    assign w_q_bit   = (w_rem_sh >= {1'b0, r_divisor});

`ifdef PWM_CAP_AVG_EN
    assign w_avg_sum = {1'b0, r_quot} + {1'b0, r_q_prev};
    assign w_div_val = r_avg;
`else
    assign w_div_val = r_quot;
`endif

    assign w_div_pub = cscap && r_div_busy && (r_div_iter == c_PUB_ITER);
    assign w_pub     = w_div_pub | w_timeout;
    assign w_pub_val = w_timeout ? {8{r_sync2}} : w_div_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= pwmin;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_per_cnt  <= '0;
            r_high_cnt <= '0;
        end else if (!cscap) begin
            r_state    <= S_IDLE;
            r_per_cnt  <= '0;
            r_high_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_per_cnt <= c_ONE;
                        r_state   <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (w_fall) begin
                        r_high_cnt <= r_per_cnt;
                        r_per_cnt  <= r_per_cnt + c_ONE;
                        r_state    <= S_LOW;
                    end else if (w_timeout) begin
                        r_per_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_per_cnt <= r_per_cnt + c_ONE;
                    end
                end
                S_LOW: begin
                    // Accepted or rejected, the next period starts counting now.
                    if (w_rise) begin
                        r_per_cnt <= c_ONE;
                        r_state   <= S_HIGH;
                    end else if (w_timeout) begin
                        r_per_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_per_cnt <= r_per_cnt + c_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_busy  <= 1'b0;
            r_div_iter  <= 4'd0;
            r_rem       <= '0;
            r_divisor   <= '0;
            r_quot      <= 8'h00;
`ifdef PWM_CAP_AVG_EN
            r_q_prev    <= 8'h00;
            r_avg       <= 8'h00;
            r_have_prev <= 1'b0;
`endif
        end else begin
            if (!cscap) begin
                r_div_busy <= 1'b0;
                r_div_iter <= 4'd0;
            end else if (w_accept) begin
                r_div_busy <= 1'b1;
                r_div_iter <= 4'd0;
                r_rem      <= r_high_cnt;
                r_divisor  <= r_per_cnt;
                r_quot     <= 8'h00;
            end else if (r_div_busy) begin
                if (r_div_iter < 4'd8) begin
                    r_rem  <= w_q_bit ? w_rem_sub : w_rem_sh[CNT_W-1:0];
                    r_quot <= {r_quot[6:0], w_q_bit};
                end
`ifdef PWM_CAP_AVG_EN
                if (r_div_iter == 4'd8) begin
                    r_avg       <= r_have_prev ? w_avg_sum[8:1] : r_quot;
                    r_q_prev    <= r_quot;
                    r_have_prev <= 1'b1;
                end
`endif
                if (w_div_pub) begin
                    r_div_busy <= 1'b0;
                end else begin
                    r_div_iter <= r_div_iter + 4'd1;
                end
            end
`ifdef PWM_CAP_AVG_EN
            if (!cscap || (r_state == S_IDLE)) begin
                r_have_prev <= 1'b0;
            end
`endif
        end
    end

    // A publish wins over a same-cycle ack; sticky bits set this cycle survive the ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sample <= 8'h00;
            r_valid  <= 1'b0;
            r_ovr    <= 1'b0;
            r_tmo    <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            if (w_pub) begin
                r_sample <= w_pub_val;
                r_valid  <= 1'b1;
            end else if (sample_ack) begin
                r_valid  <= 1'b0;
            end
            r_ovr    <= (w_pub & r_valid & ~sample_ack) | (r_ovr & ~sample_ack);
            r_tmo    <= w_timeout | (r_tmo & ~sample_ack);
            r_glitch <= w_reject | (r_glitch & ~sample_ack);
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign status       = {3'b000, r_div_busy, r_glitch, r_tmo, r_ovr, r_valid};

endmodule
`default_nettype wire
